// File: rtl/axi_stream_rr_arbiter_3_if.sv
// -----------------------------------------------------------------------------
// axi_stream -- AXI-Stream style handshake bundle used by the 3-way arbiter.
//
// Parameters
//   DATA_WIDTH : width of the data field
//   DEST_WIDTH : width of the dest routing field
//   USER_WIDTH : width of the user sideband field
//
// Signals
//   data / dest / user / tlast / valid : driven by the stream source
//   ready                              : driven by the stream sink
//
// Modports
//   master : stream source (drives payload and valid, samples ready)
//   slave  : stream sink   (samples payload and valid, drives ready)
// -----------------------------------------------------------------------------
interface axi_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int DEST_WIDTH = 2,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] data;
  logic [DEST_WIDTH-1:0] dest;
  logic [USER_WIDTH-1:0] user;
  logic                  tlast;
  logic                  valid;
  logic                  ready;

  modport master (output data, output dest, output user, output tlast, output valid, input ready);
  modport slave  (input data, input dest, input user, input tlast, input valid, output ready);
endinterface

// File: rtl/axi_stream_rr_arbiter_3.sv
// -----------------------------------------------------------------------------
// axi_stream_rr_arbiter_3 -- packet-locked round-robin arbiter, 3 streams -> 1.
//
// A requester wins the output in an IDLE cycle (round-robin search starting
// after the previous owner) and keeps it until its tlast beat is accepted.
// While locked, the output payload/valid follow the owner and the owner's
// ready follows the output ready; everybody else sees ready=0.
//
// Optional feature (compile-time macro AXIS_ARBITER_TIMEOUT_EN):
//   stall watchdog that revokes a grant after TIMEOUT_CYCLES consecutive
//   locked cycles without a handshake and pulses 'timeout' for one cycle.
//   Without the macro no counter exists and 'timeout' is constant 0.
//
// Ports
//   clock        : single rising-edge clock
//   reset        : asynchronous, active-high reset
//   stream_in_1  : requester 1 (grant index 0), axi_stream.slave
//   stream_in_2  : requester 2 (grant index 1), axi_stream.slave
//   stream_in_3  : requester 3 (grant index 2), axi_stream.slave
//   stream_out   : shared output stream, axi_stream.master
//   grant        : index of the owning requester, meaningful while busy=1
//   busy         : high while a packet owns the output
//   timeout      : one-cycle pulse when the watchdog revokes a grant
// -----------------------------------------------------------------------------
module axi_stream_rr_arbiter_3 #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clock,
  input  logic       reset,
  axi_stream.slave   stream_in_1,
  axi_stream.slave   stream_in_2,
  axi_stream.slave   stream_in_3,
  axi_stream.master  stream_out,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_n_s;
  logic [1:0]            grant_r;
  logic [1:0]            grant_n_s;
  logic [1:0]            last_grant_r;
  logic [1:0]            last_grant_n_s;
  logic                  busy_r;
  logic                  timeout_r;
  logic                  timeout_n_s;
  logic [2:0]            req_s;
  logic                  sel_valid_s;
  logic                  sel_tlast_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  hs_s;
  logic                  stall_fire_s;

  // Round-robin search: first requesting index after 'last', wrapping mod 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;
    logic [1:0] pick;
    case (last)
      2'd0: begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1: begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
    if (req[first]) begin
      pick = first;
    end else if (req[second]) begin
      pick = second;
    end else if (req[third]) begin
      pick = third;
    end else begin
      pick = 2'd0;
    end
    return pick;
  endfunction

  assign req_s = {stream_in_3.valid, stream_in_2.valid, stream_in_1.valid};

  // Output mux and ready steering; everything is quiet unless a grant is registered.
  always_comb begin
    stream_out.data  = '0;
    stream_out.dest  = '0;
    stream_out.user  = '0;
    stream_out.tlast = 1'b0;
    stream_out.valid = 1'b0;
    stream_in_1.ready = 1'b0;
    stream_in_2.ready = 1'b0;
    stream_in_3.ready = 1'b0;
    sel_data_s  = '0;
    sel_valid_s = 1'b0;
    sel_tlast_s = 1'b0;
    if (state_r == ST_LOCKED) begin
      case (grant_r)
        2'd0: begin
          sel_data_s        = stream_in_1.data;
          stream_out.dest   = stream_in_1.dest;
          stream_out.user   = stream_in_1.user;
          sel_tlast_s       = stream_in_1.tlast;
          sel_valid_s       = stream_in_1.valid;
          stream_in_1.ready = stream_out.ready;
        end
        2'd1: begin
          sel_data_s        = stream_in_2.data;
          stream_out.dest   = stream_in_2.dest;
          stream_out.user   = stream_in_2.user;
          sel_tlast_s       = stream_in_2.tlast;
          sel_valid_s       = stream_in_2.valid;
          stream_in_2.ready = stream_out.ready;
        end
        2'd2: begin
          sel_data_s        = stream_in_3.data;
          stream_out.dest   = stream_in_3.dest;
          stream_out.user   = stream_in_3.user;
          sel_tlast_s       = stream_in_3.tlast;
          sel_valid_s       = stream_in_3.valid;
          stream_in_3.ready = stream_out.ready;
        end
        default: begin
          // Index 3 is never registered; keep the output silent.
          sel_valid_s = 1'b0;
        end
      endcase
      stream_out.data  = sel_data_s;
      stream_out.tlast = sel_tlast_s;
      stream_out.valid = sel_valid_s;
    end else begin
      stream_out.valid = 1'b0;
    end
  end

  assign hs_s = sel_valid_s & stream_out.ready;

`ifdef AXIS_ARBITER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] stall_cnt_r;

  // Fires on the locked cycle that would be the TIMEOUT_CYCLES-th consecutive stall.
  assign stall_fire_s = (state_r == ST_LOCKED) && !hs_s &&
                        (stall_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: zero outside LOCKED (so entry starts clean), cleared by any handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= '0;
    end else if ((state_r != ST_LOCKED) || hs_s || stall_fire_s) begin
      stall_cnt_r <= '0;
    end else begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end
`else
  assign stall_fire_s = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, hold the grant until tlast handshake or watchdog.
  always_comb begin
    state_n_s      = state_r;
    grant_n_s      = grant_r;
    last_grant_n_s = last_grant_r;
    timeout_n_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req_s) begin
          state_n_s = ST_LOCKED;
          grant_n_s = rr_pick(req_s, last_grant_r);
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (hs_s && sel_tlast_s) begin
          state_n_s      = ST_IDLE;
          last_grant_n_s = grant_r;
        end else if (stall_fire_s) begin
          state_n_s      = ST_IDLE;
          last_grant_n_s = grant_r;
          timeout_n_s    = 1'b1;
        end else begin
          state_n_s = ST_LOCKED;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State and registered status; last_grant resets to 2 so requester 1 wins first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= 2'd0;
      last_grant_r <= 2'd2;
      busy_r       <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      grant_r      <= grant_n_s;
      last_grant_r <= last_grant_n_s;
      busy_r       <= (state_n_s == ST_LOCKED);
      timeout_r    <= timeout_n_s;
    end
  end

  assign grant   = grant_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_axi_stream_rr_arbiter_3.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_rr_arbiter_3 -- directed self-checking bench for the 3-way
// round-robin stream arbiter. Inputs change 1 time unit after the rising
// edge; outputs are checked 2 time units after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_stream_rr_arbiter_3;

  logic       clock;
  logic       reset;
  logic [1:0] grant;
  logic       busy;
  logic       timeout;

  int n_checks;
  int n_errors;

  axi_stream #(.DATA_WIDTH(16)) s1 ();
  axi_stream #(.DATA_WIDTH(16)) s2 ();
  axi_stream #(.DATA_WIDTH(16)) s3 ();
  axi_stream #(.DATA_WIDTH(16)) so ();

  axi_stream_rr_arbiter_3 #(
    .DATA_WIDTH     (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stream_in_1 (s1),
    .stream_in_2 (s2),
    .stream_in_3 (s3),
    .stream_out  (so),
    .grant       (grant),
    .busy        (busy),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drive all three requesters for the contention test: the expected owner g
  // presents beat 'beat' (tlast on beat 1), the others hold their first beat.
  task automatic drive_all(input int g, input int beat);
    s1.data = 16'h0100 + ((g == 0) ? 16'(beat) : 16'h0000);
    s2.data = 16'h0200 + ((g == 1) ? 16'(beat) : 16'h0000);
    s3.data = 16'h0300 + ((g == 2) ? 16'(beat) : 16'h0000);
    s1.tlast = (g == 0) && (beat == 1);
    s2.tlast = (g == 1) && (beat == 1);
    s3.tlast = (g == 2) && (beat == 1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    {s1.valid, s2.valid, s3.valid} = 3'b000;
    {s1.tlast, s2.tlast, s3.tlast} = 3'b000;
    s1.data = 16'h0000; s2.data = 16'h0000; s3.data = 16'h0000;
    s1.dest = 2'd1; s2.dest = 2'd2; s3.dest = 2'd3;
    s1.user = 1'b0; s2.user = 1'b1; s3.user = 1'b0;
    so.ready = 1'b1;

    // ---- reset state -------------------------------------------------------
    next_cycle();
    next_cycle();
    settle();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_grant", {30'd0, grant}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
    check_eq("rst_out_valid", {31'd0, so.valid}, 32'd0);
    check_eq("rst_in1_ready", {31'd0, s1.ready}, 32'd0);
    next_cycle();
    reset = 1'b0;

    // ---- single 4-beat packet on in_2 --------------------------------------
    next_cycle();
    s2.valid = 1'b1; s2.data = 16'h0011; s2.tlast = 1'b0;
    settle();
    check_eq("pkt_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("pkt_idle_valid", {31'd0, so.valid}, 32'd0);
    check_eq("pkt_idle_ready", {31'd0, s2.ready}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      s2.data  = 16'h0011 + 16'(b);
      s2.tlast = (b == 3);
      settle();
      check_eq("pkt_busy", {31'd0, busy}, 32'd1);
      check_eq("pkt_grant", {30'd0, grant}, 32'd1);
      check_eq("pkt_valid", {31'd0, so.valid}, 32'd1);
      check_eq("pkt_data", {16'd0, so.data}, 32'h0011 + b);
      check_eq("pkt_tlast", {31'd0, so.tlast}, (b == 3) ? 32'd1 : 32'd0);
      check_eq("pkt_dest", {30'd0, so.dest}, 32'd2);
      check_eq("pkt_ready", {31'd0, s2.ready}, 32'd1);
    end
    next_cycle();
    s2.valid = 1'b0; s2.tlast = 1'b0;
    settle();
    check_eq("pkt_end_busy", {31'd0, busy}, 32'd0);
    check_eq("pkt_end_valid", {31'd0, so.valid}, 32'd0);

    // ---- backpressure: 3-beat in_1 packet, in_2 also requesting ------------
    next_cycle();
    s1.valid = 1'b1; s1.data = 16'h0021; s1.tlast = 1'b0;
    s2.valid = 1'b1; s2.data = 16'h0099;
    settle();
    check_eq("bp_idle_valid", {31'd0, so.valid}, 32'd0);
    for (int b = 0; b < 3; b++) begin
      next_cycle();
      s1.data = 16'h0021 + 16'(b); s1.tlast = (b == 2); so.ready = 1'b0;
      settle();
      check_eq("bp_grant", {30'd0, grant}, 32'd0);
      check_eq("bp_stall_ready", {31'd0, s1.ready}, 32'd0);
      check_eq("bp_stall_data", {16'd0, so.data}, 32'h0021 + b);
      next_cycle();
      so.ready = 1'b1;
      settle();
      check_eq("bp_go_ready", {31'd0, s1.ready}, 32'd1);
      check_eq("bp_go_data", {16'd0, so.data}, 32'h0021 + b);
      check_eq("bp_in2_ready", {31'd0, s2.ready}, 32'd0);
      check_eq("bp_in3_ready", {31'd0, s3.ready}, 32'd0);
    end
    next_cycle();
    s1.valid = 1'b0; s2.valid = 1'b0; s1.tlast = 1'b0;
    settle();
    check_eq("bp_end_busy", {31'd0, busy}, 32'd0);

    // ---- contention after reset: order 0,1,2,0 with one idle cycle ---------
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    {s1.valid, s2.valid, s3.valid} = 3'b111;
    drive_all(0, 0);
    settle();
    check_eq("rr_first_idle", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive_all(k % 3, 0);
      settle();
      check_eq("rr_grant", {30'd0, grant}, 32'(k % 3));
      check_eq("rr_busy", {31'd0, busy}, 32'd1);
      check_eq("rr_data0", {16'd0, so.data}, 32'h0100 * ((k % 3) + 1));
      next_cycle();
      drive_all(k % 3, 1);
      settle();
      check_eq("rr_hold_grant", {30'd0, grant}, 32'(k % 3));
      check_eq("rr_tlast", {31'd0, so.tlast}, 32'd1);
      next_cycle();
      drive_all((k + 1) % 3, 0);
      if (k == 3) {s1.valid, s2.valid, s3.valid} = 3'b000;
      settle();
      check_eq("rr_gap_busy", {31'd0, busy}, 32'd0);
      check_eq("rr_gap_valid", {31'd0, so.valid}, 32'd0);
    end

    // ---- reset mid-packet on a 4-beat in_3 packet --------------------------
    {s1.tlast, s2.tlast, s3.tlast} = 3'b000;
    next_cycle();
    s3.valid = 1'b1; s3.data = 16'h0031;
    next_cycle();
    settle();
    check_eq("mid_grant", {30'd0, grant}, 32'd2);
    check_eq("mid_data1", {16'd0, so.data}, 32'h0031);
    next_cycle();
    s3.data = 16'h0032;
    settle();
    check_eq("mid_data2", {16'd0, so.data}, 32'h0032);
    next_cycle();
    s3.data = 16'h0033;
    s1.valid = 1'b1; s1.data = 16'h0041; s1.tlast = 1'b0;
    settle();
    check_eq("mid_pre_valid", {31'd0, so.valid}, 32'd1);
    reset = 1'b1;
    settle();
    check_eq("mid_rst_valid", {31'd0, so.valid}, 32'd0);
    check_eq("mid_rst_in3_ready", {31'd0, s3.ready}, 32'd0);
    check_eq("mid_rst_in1_ready", {31'd0, s1.ready}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_grant", {30'd0, grant}, 32'd0);
    next_cycle();
    reset = 1'b0;
    settle();
    check_eq("mid_rel_busy", {31'd0, busy}, 32'd0);
    next_cycle();
    s3.valid = 1'b0;
    s2.valid = 1'b1; s2.data = 16'h0051; s2.tlast = 1'b0;
    settle();
    check_eq("after_rst_grant", {30'd0, grant}, 32'd0);
    check_eq("after_rst_busy", {31'd0, busy}, 32'd1);
    check_eq("after_rst_data", {16'd0, so.data}, 32'h0041);

    // ---- stall watchdog: in_1 sent one beat, now drops valid ---------------
    next_cycle();
    s1.valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      settle();
      check_eq("stall_busy", {31'd0, busy}, 32'd1);
      check_eq("stall_timeout", {31'd0, timeout}, 32'd0);
      check_eq("stall_in2_ready", {31'd0, s2.ready}, 32'd0);
      next_cycle();
    end
    settle();
`ifdef AXIS_ARBITER_TIMEOUT_EN
    check_eq("to_pulse", {31'd0, timeout}, 32'd1);
    check_eq("to_busy", {31'd0, busy}, 32'd0);
    check_eq("to_valid", {31'd0, so.valid}, 32'd0);
    next_cycle();
    settle();
    check_eq("to_pulse_end", {31'd0, timeout}, 32'd0);
    check_eq("to_next_grant", {30'd0, grant}, 32'd1);
    check_eq("to_next_busy", {31'd0, busy}, 32'd1);
    check_eq("to_next_data", {16'd0, so.data}, 32'h0051);
`else
    check_eq("hold_timeout", {31'd0, timeout}, 32'd0);
    check_eq("hold_busy", {31'd0, busy}, 32'd1);
    check_eq("hold_grant", {30'd0, grant}, 32'd0);
    next_cycle();
    settle();
    check_eq("hold_busy2", {31'd0, busy}, 32'd1);
    check_eq("hold_in2_ready", {31'd0, s2.ready}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
